gen_fifo_rd_prefetch: RTL and testbench

//  Read-side prefetch stage downstream of the async FIFO controller (rclk domain).

---
 rtl/gen_fifo_rd_prefetch_if.sv | 24 ++
 rtl/gen_fifo_rd_prefetch.sv | 110 +++++++++++
 tb/tb_gen_fifo_rd_prefetch.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gen_fifo_rd_prefetch_if.sv
// rtl/gen_fifo_rd_prefetch_if.sv - FIFO-controller and consumer-side signals of the read prefetch stage
// master = prefetch stage, slave = FIFO controller/RAM plus the consumer.
interface gen_fifo_rd_prefetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_AW     = 1
);
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [BUF_AW:0]       out_level;

    modport master (
        input  fifo_empty, ram_rdata, out_ready,
        output fifo_pop, out_valid, out_data, out_level
    );

    modport slave (
        output fifo_empty, ram_rdata, out_ready,
        input  fifo_pop, out_valid, out_data, out_level
    );
endinterface

// File: rtl/gen_fifo_rd_prefetch.sv
// rtl/gen_fifo_rd_prefetch.sv - read-side prefetch: credit-based pop, RD_LAT return pipe, output buffer
// Pops whenever buffer space covers everything already in flight; the head word is registered.
module gen_fifo_rd_prefetch #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1,
    parameter int BUF_AW     = 1
) (
    input  logic                   rclk,
    input  logic                   rreset,
    input  logic                   flush,
    gen_fifo_rd_prefetch_if.master bus
);
    localparam int BUF_D = 1 << BUF_AW;
    localparam int LW    = BUF_AW + 1;
    localparam int CW    = BUF_AW + 2;

    logic [RD_LAT-1:0]     pipe_q, pipe_d;
    logic [BUF_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [BUF_AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mem_q [BUF_D];
    logic [DATA_WIDTH-1:0] mem_d [BUF_D];

    logic [CW-1:0]         inflight;
    logic [CW-1:0]         credit;
    logic                  pop;
    logic                  pop_acc;
    logic                  ret;
    logic                  deq;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(pipe_q[i]);
        end
    end

    assign ret     = pipe_q[RD_LAT-1];
    assign deq     = valid_q & bus.out_ready;
    // Words already returning or in flight are counted as occupied, so a full-rate
    // stream never needs more than RD_LAT+1 slots and can never overflow.
    assign credit  = CW'(level_q) + inflight - CW'(deq);
    assign pop     = ~rreset & ~flush & ~bus.fifo_empty & (credit < CW'(BUF_D));
    assign pop_acc = pop & ~bus.fifo_empty;

    always_comb begin
        pipe_d   = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        valid_d  = valid_q;
        data_d   = data_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            valid_d  = 1'b0;
            data_d   = '0;
        end else begin
            pipe_d[0] = pop_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
            if (ret) begin
                mem_d[wr_ptr_q] = bus.ram_rdata;
                wr_ptr_d        = wr_ptr_q + BUF_AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + BUF_AW'(1);
            end
            level_d = level_q + LW'(ret) - LW'(deq);
            valid_d = (level_d != '0);
            // Reading the post-write array lets a returning word land straight on the head.
            data_d  = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge rclk) begin
        if (rreset) begin
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            for (int i = 0; i < BUF_D; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pipe_q   <= pipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            mem_q    <= mem_d;
        end
    end

    assign bus.fifo_pop  = pop;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_level = level_q;

    ovf_chk: assert property (@(posedge rclk) disable iff (rreset || flush)
        !(ret && !deq && level_q == LW'(BUF_D)));
endmodule

// File: tb/tb_gen_fifo_rd_prefetch.sv
// tb/tb_gen_fifo_rd_prefetch.sv - directed bench for gen_fifo_rd_prefetch (RD_LAT=1/BUF_AW=1 and RD_LAT=3/BUF_AW=2)
module tb_gen_fifo_rd_prefetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush_a, flush_b;
    logic rdy_a, rdy_b;
    logic gap_a;

    int n_cmp = 0;
    int n_bad = 0;

    gen_fifo_rd_prefetch_if #(.DATA_WIDTH(32), .BUF_AW(1)) bus_a ();
    gen_fifo_rd_prefetch_if #(.DATA_WIDTH(32), .BUF_AW(2)) bus_b ();

    gen_fifo_rd_prefetch #(.DATA_WIDTH(32), .RD_LAT(1), .BUF_AW(1)) dut_a (
        .rclk   (clk),
        .rreset (rst),
        .flush  (flush_a),
        .bus    (bus_a.master)
    );

    gen_fifo_rd_prefetch #(.DATA_WIDTH(32), .RD_LAT(3), .BUF_AW(2)) dut_b (
        .rclk   (clk),
        .rreset (rst),
        .flush  (flush_b),
        .bus    (bus_b.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO controller + RAM model, instance A (read latency 1)
    logic [31:0] mem_a [64];
    int unsigned wr_a = 0, rd_a = 0;
    logic [31:0] rpipe_a;
    logic [31:0] exp_a [$];

    assign bus_a.fifo_empty = (wr_a == rd_a) || gap_a;
    assign bus_a.ram_rdata  = rpipe_a;
    assign bus_a.out_ready  = rdy_a;

    always @(posedge clk) begin
        if (flush_a) rd_a <= wr_a;
        else if (bus_a.fifo_pop && !bus_a.fifo_empty) rd_a <= rd_a + 1;
        rpipe_a <= (bus_a.fifo_pop && !bus_a.fifo_empty) ? mem_a[rd_a % 64] : 32'hDEAD_BEEF;
    end

    // FIFO controller + RAM model, instance B (read latency 3)
    logic [31:0] mem_b [64];
    int unsigned wr_b = 0, rd_b = 0;
    logic [31:0] rpipe_b [3];
    logic [31:0] exp_b [$];

    assign bus_b.fifo_empty = (wr_b == rd_b);
    assign bus_b.ram_rdata  = rpipe_b[2];
    assign bus_b.out_ready  = rdy_b;

    always @(posedge clk) begin
        if (flush_b) rd_b <= wr_b;
        else if (bus_b.fifo_pop && !bus_b.fifo_empty) rd_b <= rd_b + 1;
        rpipe_b[0] <= (bus_b.fifo_pop && !bus_b.fifo_empty) ? mem_b[rd_b % 64] : 32'hDEAD_BEEF;
        rpipe_b[1] <= rpipe_b[0];
        rpipe_b[2] <= rpipe_b[1];
    end

    task automatic push_a(input logic [31:0] w);
        mem_a[wr_a % 64] = w;
        exp_a.push_back(w);
        wr_a++;
    endtask

    task automatic push_b(input logic [31:0] w);
        mem_b[wr_b % 64] = w;
        exp_b.push_back(w);
        wr_b++;
    endtask

    // Scoreboards: every accepted word must be the oldest one still expected.
    always @(negedge clk) begin
        if (!rst && !flush_a && bus_a.out_valid && bus_a.out_ready) begin
            if (exp_a.size() == 0) check("a_phantom_q", exp_a.size(), 1);
            else check("a_data", bus_a.out_data, exp_a.pop_front());
        end
        if (!rst && !flush_b && bus_b.out_valid && bus_b.out_ready) begin
            if (exp_b.size() == 0) check("b_phantom_q", exp_b.size(), 1);
            else check("b_data", bus_b.out_data, exp_b.pop_front());
        end
    end

    task automatic wait_drain_a(input int max);
        int n = 0;
        while (exp_a.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("a_drain", exp_a.size(), 0);
    endtask

    task automatic wait_drain_b(input int max);
        int n = 0;
        while (exp_b.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("b_drain", exp_b.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
        rdy_a = 1'b0; rdy_b = 1'b0; gap_a = 1'b0;
        for (int k = 1; k <= 16; k++) push_a(32'(k));

        // reset held 3 clocks with the FIFO non-empty
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_pop",   bus_a.fifo_pop, 0);
            check("rst_valid", bus_a.out_valid, 0);
            check("rst_level", bus_a.out_level, 0);
            check("rst_data",  bus_a.out_data, 0);
        end
        rst = 1'b0; rdy_a = 1'b1;

        // streaming, RD_LAT=1
        @(negedge clk);
        check("first_pop", bus_a.fifo_pop, 1);
        check("first_pop_valid", bus_a.out_valid, 0);
        @(negedge clk);
        check("lat_valid", bus_a.out_valid, 0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("stream_valid", bus_a.out_valid, 1);
            check("stream_data", bus_a.out_data, 32'(k));
        end
        @(negedge clk);
        check("stream_end_valid", bus_a.out_valid, 0);
        check("stream_pops", rd_a, 16);

        // backpressure
        @(posedge clk); #1;
        rdy_a = 1'b0;
        for (int k = 0; k < 6; k++) push_a(32'h21 + 32'(k));
        repeat (6) @(negedge clk);
        check("bp_pops", rd_a - 16, 2);
        check("bp_level", bus_a.out_level, 2);
        check("bp_pop", bus_a.fifo_pop, 0);
        check("bp_head", bus_a.out_data, 32'h21);
        @(posedge clk); #1;
        rdy_a = 1'b1;
        wait_drain_a(40);
        check("bp_total_pops", rd_a, 22);

        // FIFO toggling empty every clock
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) push_a(32'h31 + 32'(k));
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            gap_a = ~gap_a;
            @(negedge clk);
            check("gap_level", bus_a.out_level <= 2, 1);
            check("gap_pop_empty", bus_a.fifo_pop & bus_a.fifo_empty, 0);
        end
        @(posedge clk); #1;
        gap_a = 1'b0;
        wait_drain_a(40);
        check("gap_total_pops", rd_a, 30);

        // flush on B with level 2 and one word in flight
        @(posedge clk); #1;
        push_b(32'h41); push_b(32'h42); push_b(32'h43);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_b.out_level != 1 && n < 20);
        check("b_level1_seen", bus_b.out_level, 1);
        @(posedge clk); #1;
        check("b_pre_flush_level", bus_b.out_level, 2);
        push_b(32'h44);
        flush_b = 1'b1;
        exp_b.delete();
        check("b_flush_pop", bus_b.fifo_pop, 0);
        @(posedge clk); #1;
        flush_b = 1'b0;
        @(negedge clk);
        check("b_flush_valid", bus_b.out_valid, 0);
        check("b_flush_level", bus_b.out_level, 0);
        repeat (4) begin
            @(negedge clk);
            check("b_dropped_level", bus_b.out_level, 0);
        end
        @(posedge clk); #1;
        push_b(32'h51); push_b(32'h52);
        rdy_b = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus_b.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_post_flush_first", bus_b.out_data, 32'h51);
        wait_drain_b(40);

        // RD_LAT=3, random backpressure
        @(posedge clk); #1;
        for (int k = 0; k < 32; k++) push_b(32'h100 + 32'(k));
        n = 0;
        while (exp_b.size() != 0 && n < 600) begin
            @(posedge clk); #1;
            rdy_b = 1'($urandom_range(0, 1));
            n++;
        end
        check("b_rand_drain", exp_b.size(), 0);
        @(negedge clk);
        check("b_rand_pops", rd_b, wr_b);

        // RD_LAT=3 full rate
        @(posedge clk); #1;
        rdy_b = 1'b1;
        for (int k = 1; k <= 16; k++) push_b(32'h200 + 32'(k));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_b.out_valid && n < 20);
        for (int k = 1; k <= 16; k++) begin
            check("b_fr_valid", bus_b.out_valid, 1);
            check("b_fr_data", bus_b.out_data, 32'h200 + 32'(k));
            @(negedge clk);
        end
        check("b_fr_end_valid", bus_b.out_valid, 0);
        check("b_fr_end_level", bus_b.out_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
